// File: rtl/fsm_count_seq.sv
// Button-driven up/down count sequencer with pause/resume, auto-restart and a
// Mealy done pulse; the internal divider produces a clock enable (tick).
module fsm_count_seq #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned DIV_MAX = 1500000,
  parameter int unsigned DIV_W   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go_n,
  input  logic             pause_n,
  input  logic             dir,
  input  logic [CNT_W-1:0] limit,
  input  logic             auto_restart,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COUNTING = 2'd1,
    S_PAUSED   = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   limit_q, limit_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  // [0],[1] synchroniser stages; [2] previous synchronised level for edge detect
  logic [2:0]         go_sync_q, go_sync_d;
  logic [2:0]         pause_sync_q, pause_sync_d;

  logic               go_press;
  logic               pause_press;
  logic               tick;
  logic               terminal;
  logic [CNT_W-1:0]   start_val;

  // Falling edge of the synchronised active-low button is one press
  assign go_press    = go_sync_q[2] & ~go_sync_q[1];
  assign pause_press = pause_sync_q[2] & ~pause_sync_q[1];
  assign tick        = (div_q == DIV_W'(DIV_MAX));
  assign terminal    = dir_q ? (count_q == '0) : (count_q == limit_q);
  assign start_val   = dir_q ? limit_q : '0;

  // Next-state, divider, count and Mealy done logic
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    limit_d      = limit_q;
    div_d        = div_q;
    dir_d        = dir_q;
    done         = 1'b0;
    go_sync_d    = {go_sync_q[1:0], go_n};
    pause_sync_d = {pause_sync_q[1:0], pause_n};

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go_press) begin
          state_d = S_COUNTING;
          dir_d   = dir;
          limit_d = limit;
          count_d = dir ? limit : '0;
          div_d   = '0;
        end
      end
      S_COUNTING: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (tick) begin
          if (terminal) begin
            // Terminal tick takes priority; a coincident pause press is dropped
            done = 1'b1;
            if (auto_restart) begin
              count_d = start_val;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            count_d = dir_q ? count_q - CNT_W'(1) : count_q + CNT_W'(1);
            if (pause_press) begin
              state_d = S_PAUSED;
            end
          end
        end else if (pause_press) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        // Abort beats resume when both buttons land together
        if (go_press) begin
          state_d = S_IDLE;
          count_d = '0;
          div_d   = '0;
        end else if (pause_press) begin
          state_d = S_COUNTING;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
        div_d   = '0;
      end
    endcase

    busy_d = (state_d == S_COUNTING) || (state_d == S_PAUSED);
  end

  // State and datapath registers; sync chains reset to the released level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      limit_q      <= '0;
      div_q        <= '0;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      go_sync_q    <= 3'b111;
      pause_sync_q <= 3'b111;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      limit_q      <= limit_d;
      div_q        <= div_d;
      dir_q        <= dir_d;
      busy_q       <= busy_d;
      go_sync_q    <= go_sync_d;
      pause_sync_q <= pause_sync_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign state = state_q;

endmodule

// File: tb/tb_fsm_count_seq.sv
// Scoreboard bench for fsm_count_seq: stimulus pushes expected output events
// (count/state/busy/done plus cycle gap), a monitor pops on every output change.
module tb_fsm_count_seq;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DIV_MAX = 3;
  localparam int unsigned DIV_W   = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CNT  = 2'd1;
  localparam logic [1:0] ST_PSD  = 2'd2;
  localparam logic [1:0] ST_DN   = 2'd3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             go_n = 1'b1;
  logic             pause_n = 1'b1;
  logic             dir = 1'b0;
  logic [CNT_W-1:0] limit = '0;
  logic             auto_restart = 1'b0;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  typedef struct {
    logic [3:0] count;
    logic [1:0] st;
    logic       busy;
    logic       done;
    int         gap;   // cycles since previous event; 0 = not checked
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  fsm_count_seq #(.CNT_W(CNT_W), .DIV_MAX(DIV_MAX), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .go_n(go_n), .pause_n(pause_n), .dir(dir),
    .limit(limit), .auto_restart(auto_restart), .count(count), .busy(busy),
    .done(done), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input logic [3:0] c, input logic [1:0] s, input logic b,
                      input logic d, input int g);
    ev_t e;
    e.count = c; e.st = s; e.busy = b; e.done = d; e.gap = g;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Wait until the monitor has consumed every pending expectation
  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d events still pending after %0d cycles, required 0",
               name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  // Monitor: every change of the output tuple must match the next expectation
  initial begin : monitor
    logic [7:0] prev;
    logic [7:0] cur;
    int         last_cyc;
    ev_t        e;
    prev     = 8'h00;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      cur = {count, state, busy, done};
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got count=%0d state=%0d busy=%0b done=%0b at cycle %0d, required no event",
                   count, state, busy, done, cyc);
        end else begin
          e = exp_q.pop_front();
          if (count !== e.count || state !== e.st || busy !== e.busy ||
              done !== e.done || (e.gap != 0 && (cyc - last_cyc) != e.gap)) begin
            errors++;
            $display("FAIL event: got count=%0d state=%0d busy=%0b done=%0b gap=%0d, required count=%0d state=%0d busy=%0b done=%0b gap=%0d",
                     count, state, busy, done, cyc - last_cyc,
                     e.count, e.st, e.busy, e.done, e.gap);
          end
        end
        prev     = cur;
        last_cyc = cyc;
      end
    end
  end

  // Directed stimulus
  initial begin : stim
    #1 rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);
    chk("reset_count", int'(count), 0);
    chk("reset_state", int'(state), int'(ST_IDLE));
    chk("reset_busy",  int'(busy), 0);
    chk("reset_done",  int'(done), 0);

    // 1: count up to 5
    dir = 1'b0; limit = 4'd5; auto_restart = 1'b0;
    go_n = 1'b0;
    push(4'd0, ST_CNT, 1'b1, 1'b0, 0);
    drain("t1_start", 20);
    go_n = 1'b1;
    for (int i = 1; i <= 5; i++) push(4'(i), ST_CNT, 1'b1, 1'b0, 4);
    push(4'd5, ST_CNT, 1'b1, 1'b1, 3);
    push(4'd5, ST_DN, 1'b0, 1'b0, 1);
    drain("t1_run", 60);

    // 2: count down from 3
    dir = 1'b1; limit = 4'd3;
    go_n = 1'b0;
    push(4'd3, ST_CNT, 1'b1, 1'b0, 0);
    drain("t2_start", 20);
    go_n = 1'b1;
    push(4'd2, ST_CNT, 1'b1, 1'b0, 4);
    push(4'd1, ST_CNT, 1'b1, 1'b0, 4);
    push(4'd0, ST_CNT, 1'b1, 1'b0, 4);
    push(4'd0, ST_CNT, 1'b1, 1'b1, 3);
    push(4'd0, ST_DN, 1'b0, 1'b0, 1);
    drain("t2_run", 60);

    // 3: auto-restart wraps twice, then stops once auto_restart drops
    dir = 1'b0; limit = 4'd2; auto_restart = 1'b1;
    go_n = 1'b0;
    push(4'd0, ST_CNT, 1'b1, 1'b0, 0);
    drain("t3_start", 20);
    go_n = 1'b1;
    for (int w = 0; w < 2; w++) begin
      push(4'd1, ST_CNT, 1'b1, 1'b0, 4);
      push(4'd2, ST_CNT, 1'b1, 1'b0, 4);
      push(4'd2, ST_CNT, 1'b1, 1'b1, 3);
      push(4'd0, ST_CNT, 1'b1, 1'b0, 1);
    end
    drain("t3_wrap", 60);
    auto_restart = 1'b0;
    push(4'd1, ST_CNT, 1'b1, 1'b0, 4);
    push(4'd2, ST_CNT, 1'b1, 1'b0, 4);
    push(4'd2, ST_CNT, 1'b1, 1'b1, 3);
    push(4'd2, ST_DN, 1'b0, 1'b0, 1);
    drain("t3_stop", 60);

    // 4: pause at 2, resume, pause at 3, abort
    dir = 1'b0; limit = 4'd5;
    go_n = 1'b0;
    push(4'd0, ST_CNT, 1'b1, 1'b0, 0);
    drain("t4_start", 20);
    go_n = 1'b1;
    push(4'd1, ST_CNT, 1'b1, 1'b0, 4);
    push(4'd2, ST_CNT, 1'b1, 1'b0, 4);
    drain("t4_to2", 40);
    pause_n = 1'b0;
    push(4'd2, ST_PSD, 1'b1, 1'b0, 3);
    drain("t4_pause", 20);
    pause_n = 1'b1;
    step(20);
    pause_n = 1'b0;
    push(4'd2, ST_CNT, 1'b1, 1'b0, 23);
    drain("t4_resume", 20);
    pause_n = 1'b1;
    push(4'd3, ST_CNT, 1'b1, 1'b0, 1);
    drain("t4_step", 20);
    pause_n = 1'b0;
    push(4'd3, ST_PSD, 1'b1, 1'b0, 3);
    drain("t4_pause2", 20);
    go_n = 1'b0;
    push(4'd0, ST_IDLE, 1'b0, 1'b0, 3);
    drain("t4_abort", 20);
    go_n = 1'b1;
    pause_n = 1'b1;
    step(5);

    // 5: limit 0, then pause landing on the terminal tick
    limit = 4'd0;
    go_n = 1'b0;
    push(4'd0, ST_CNT, 1'b1, 1'b0, 0);
    drain("t5_start", 20);
    go_n = 1'b1;
    push(4'd0, ST_CNT, 1'b1, 1'b1, 3);
    push(4'd0, ST_DN, 1'b0, 1'b0, 1);
    drain("t5_done", 20);
    go_n = 1'b0;
    push(4'd0, ST_CNT, 1'b1, 1'b0, 0);
    drain("t5_restart", 20);
    go_n = 1'b1;
    step(1);
    pause_n = 1'b0;
    push(4'd0, ST_CNT, 1'b1, 1'b1, 3);
    push(4'd0, ST_DN, 1'b0, 1'b0, 1);
    drain("t5_pause_on_tick", 20);
    step(10);
    pause_n = 1'b1;
    step(3);

    // 6: reset mid-count with go held low through release
    limit = 4'd5;
    go_n = 1'b0;
    push(4'd0, ST_CNT, 1'b1, 1'b0, 0);
    drain("t6_start", 20);
    push(4'd1, ST_CNT, 1'b1, 1'b0, 4);
    push(4'd2, ST_CNT, 1'b1, 1'b0, 4);
    drain("t6_to2", 40);
    rst = 1'b1;
    push(4'd0, ST_IDLE, 1'b0, 1'b0, 0);
    step(2);
    rst = 1'b0;
    push(4'd0, ST_CNT, 1'b1, 1'b0, 4);
    for (int i = 1; i <= 5; i++) push(4'(i), ST_CNT, 1'b1, 1'b0, 4);
    push(4'd5, ST_CNT, 1'b1, 1'b1, 3);
    push(4'd5, ST_DN, 1'b0, 1'b0, 1);
    drain("t6_rerun", 100);
    step(20);
    go_n = 1'b1;
    step(5);
    chk("t6_final_state", int'(state), int'(ST_DN));
    chk("t6_final_count", int'(count), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
